// File: rtl/fa_cell.sv
// One-bit full adder cell: the only arithmetic in the serial adder.
// Purely combinational; the caller owns the carry storage.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: LSB-first through one full-adder cell and a carry flop.
// Result, carry-out and signed overflow are presented with a one-cycle done strobe.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s, fa_cout;

  fa_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d            = fa_cout;
        sum_d              = sum_q >> 1;
        sum_d[WIDTH-1]     = fa_s;
        a_sh_d             = a_sh_q >> 1;
        b_sh_d             = b_sh_q >> 1;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB.
          state_d = DONE;
          c_out_d = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1 with hand-computed results.
// One line per transaction; FAIL lines on mismatch; one summary line at the end.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, c_out8, ovf8;
  logic [7:0] sum8;

  logic start1 = 1'b0, sub1 = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0;
  logic busy1, done1, c_out1, ovf1;
  logic sum1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Start one WIDTH=8 operation and wait for done; returns latency and busy-high count.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                      output int lat, output int nbusy);
    @(negedge clk);
    a8 = ia; b8 = ib; sub8 = isub; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; nbusy = 0;
    while (!done8 && lat < 20) begin
      if (busy8) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                     input logic isub, input logic [7:0] es, input logic ec, input logic eo);
    int lat, nbusy;
    run8(ia, ib, isub, lat, nbusy);
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_busy"}, 32'(nbusy), 32'd8);
    chk({tag, "_busy_at_done"}, 32'(busy8), 32'd0);
    chk({tag, "_sum"}, 32'(sum8), 32'(es));
    chk({tag, "_cout"}, 32'(c_out8), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf8), 32'(eo));
    $display("op %s a=%02h b=%02h sub=%0d -> sum=%02h c_out=%0d ovf=%0d lat=%0d",
             tag, ia, ib, isub, sum8, c_out8, ovf8, lat);
  endtask

  task automatic op1(input string tag, input logic ia, input logic ib, input logic isub,
                     input logic es, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a1 = ia; b1 = ib; sub1 = isub; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk({tag, "_busy"}, 32'(busy1), 32'd1);
    lat = 0;
    while (!done1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_sum"}, 32'(sum1), 32'(es));
    chk({tag, "_cout"}, 32'(c_out1), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf1), 32'(eo));
    $display("op %s a=%0d b=%0d sub=%0d -> sum=%0d c_out=%0d ovf=%0d lat=%0d",
             tag, ia, ib, isub, sum1, c_out1, ovf1, lat);
  endtask

  initial begin
    int n, seen_done;

    #12;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(c_out8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    $display("reset checked");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    op8("add5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    op8("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("sub1020", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);

    // Start pulse mid-RUN is ignored; start held in the done cycle is accepted.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      if (n == 2) begin
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("ign_lat", 32'(n), 32'd8);
    chk("ign_sum", 32'(sum8), 32'h8D);
    chk("ign_cout", 32'(c_out8), 32'd0);
    chk("ign_ovf", 32'(ovf8), 32'd1);
    $display("op ignore-midrun sum=%02h lat=%0d", sum8, n);
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1; start8 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      start8 = 1'b0;
    end while (!done8 && n < 20);
    chk("b2b_gap", 32'(n), 32'd9);
    chk("b2b_sum", 32'(sum8), 32'hF0);
    chk("b2b_cout", 32'(c_out8), 32'd0);
    $display("op back-to-back sum=%02h gap=%0d", sum8, n);

    // Reset during RUN cycle 3 aborts with no done.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_cout", 32'(c_out8), 32'd0);
    chk("abort_ovf", 32'(ovf8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    $display("op reset-abort checked");
    op8("add0102", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    op1("w1_add11", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    op1("w1_sub01", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
